rvv_rs_fifo: RTL and testbench
==============================

Name: rvv_rs_fifo

Overview:
- Reservation-station buffer sitting directly downstream of the dispatch stage; one instance per execution unit (ALU, PMT+RDT, MUL, DIV, LSU).
- Accepts up to NUM_PUSH in-order entries per cycle over per-lane valid/ready.
- Presents the oldest entry to the execution unit over a single valid/ready pop port.
- Supports a synchronous flush for trap/rollback.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- DATA_WIDTH, 64, payload width in bits; set to $bits of the unit's RS struct, e.g. ALU_RS_t.
- NUM_PUSH, 2, push lanes; equals `NUM_DP_RS.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries.
- push_valid  input  [NUM_PUSH-1:0]  per-lane push request from dispatch.
- push_data  input  [NUM_PUSH-1:0][DATA_WIDTH-1:0]  per-lane payload.
- push_ready  output  [NUM_PUSH-1:0]  per-lane accept.
- pop_valid  output  1  head entry valid to execution unit.
- pop_data  output  DATA_WIDTH  head entry payload.
- pop_ready  input  1  execution unit consumes head.
- count  output  CNT_W  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array. Write pointer wp and read pointer rp are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a separate count register (full/empty never inferred from pointer equality).
- Reset: while rst is high, wp=rp=0, count=0 and storage is zeroed. Outputs during reset: pop_valid=0, pop_data=0, full=0, empty=1, count=0, push_ready forced to all 0. All pushes and pops are ignored while rst is high.
- push_ready[i] depends only on registered state, never on push_valid or pop_ready in the same cycle:
  - push_ready[i] = !rst && !flush && (DEPTH - count) >= i+1.
  - No pop-through credit: a full FIFO deasserts push_ready[0] even when pop_ready=1 in that cycle.
- Lane ordering: lane 0 is older than lane 1.
  - Upstream never asserts push_valid[1] without push_valid[0] in the same cycle. This is a bench assertion, not handled in RTL.
  - Accepted lanes are written to wp, wp+1 (mod DEPTH) in lane order.
- Push count: npush = number of lanes with push_valid[i] && push_ready[i] (0..NUM_PUSH).
- Pop:
  - pop_valid = !empty; pop_data = storage[rp]. Both come straight from registers, giving zero-cycle latency from storage to output.
  - npop = pop_valid && pop_ready.
  - A newly pushed entry becomes visible on pop_valid the cycle after the push edge, so an empty FIFO has no same-cycle bypass.
- Update each edge, when not flushing: wp += npush; rp += npop; count += npush - npop. Simultaneous push and pop are legal in every state, including count==DEPTH-1 with 2 lanes ready and count==1 with a pop.
- flush:
  - Highest priority after rst.
  - On the edge: wp=rp=0, count=0. Storage is not cleared.
  - Any push or pop presented in the flush cycle is discarded: push_ready is 0 so no push handshake occurs. pop_valid may still be high, but the entry is dropped and is not considered consumed.
- Reset mid-operation: rst asserted asynchronously at any point clears all state immediately, regardless of clock.
- Invariants, asserted in the bench: count <= DEPTH; count == (wp - rp) mod DEPTH, except when count==DEPTH, where wp==rp.

Test Plan:
- Reset, then push lane0 only with data A, B, C on 3 consecutive cycles, pop_ready=0 -> count=3; pop_valid rises the cycle after A; pop_data=A.
- Dual push every cycle, pop_ready=0, DEPTH=8 -> accepted after 4 cycles; count=8, full=1, push_ready=00. At count=7, push_ready=01 and only lane 0 is accepted.
- Fill to 8, hold push_valid=11 with pop_ready=1 -> one pop per cycle, push_ready stays 00 that cycle (no pop-through). The next cycle shows count=7, push_ready=01.
- Stream 20 dual pushes with random pop_ready -> output order exactly matches push order across pointer wrap; no loss or duplication.
- Flush at count=5 with push_valid=11 and pop_ready=1 in the same cycle -> next cycle count=0, empty=1, pop_valid=0; no entry consumed or added.
- Assert rst asynchronously mid-stream at count=6 -> pop_valid=0, count=0 and push_ready=00 immediately; after deassertion, push_ready=11.

Source files
------------

// File: rtl/rvv_rs_fifo_if.sv
// Dispatch-to-RS push lanes and RS-to-execution-unit pop port.
// The FIFO takes the slave side of this bundle.
interface rvv_rs_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PUSH   = 2
) ();
  logic [NUM_PUSH-1:0]                 push_valid;
  logic [NUM_PUSH-1:0][DATA_WIDTH-1:0] push_data;
  logic [NUM_PUSH-1:0]                 push_ready;
  logic                                pop_valid;
  logic [DATA_WIDTH-1:0]               pop_data;
  logic                                pop_ready;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/rvv_rs_fifo.sv
// Multi-lane-push, single-pop reservation-station FIFO with flush.
// Occupancy lives in its own counter; pointers only address storage.
module rvv_rs_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PUSH   = 2,
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  rvv_rs_fifo_if.slave     io,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wp_q, wp_d;
  logic [PTR_W-1:0]      rp_q, rp_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      free;
  logic [CNT_W-1:0]      npush;
  logic                  npop;
  logic [NUM_PUSH-1:0]   ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  // Ready is a function of registered occupancy only: no pop-through credit.
  always_comb begin
    free = CNT_W'(DEPTH) - count_q;
    for (int i = 0; i < NUM_PUSH; i++)
      ready[i] = !rst && !flush && (free > CNT_W'(i));
  end

  always_comb begin
    mem_d = mem_q;
    npush = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (io.push_valid[i] && ready[i]) begin
        mem_d[wp_q + npush[PTR_W-1:0]] = io.push_data[i];
        npush = npush + CNT_W'(1);
      end
    end
    npop = (count_q != '0) && io.pop_ready;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      wp_d    = wp_q + npush[PTR_W-1:0];
      rp_d    = rp_q + PTR_W'(npop);
      count_d = count_q + npush - CNT_W'(npop);
    end
  end

  assign io.push_ready = ready;
  assign io.pop_valid  = (count_q != '0);
  assign io.pop_data   = mem_q[rp_q];
  assign count         = count_q;
  assign full          = (count_q == CNT_W'(DEPTH));
  assign empty         = (count_q == '0);
endmodule

// File: tb/tb_rvv_rs_fifo.sv
// Scoreboard bench for rvv_rs_fifo: stimulus queues accepted pushes,
// a negedge monitor pops and compares on every pop handshake.
module tb_rvv_rs_fifo;
  localparam int DEPTH = 8;
  localparam int DW    = 64;
  localparam int NP    = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  rvv_rs_fifo_if #(.DATA_WIDTH(DW), .NUM_PUSH(NP)) io ();

  rvv_rs_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_PUSH(NP)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .io(io),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] sb [$];
  int mcnt = 0;
  logic [DW-1:0] seq = 64'h1000;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop checking plus structural invariants.
  always @(negedge clk) begin
    logic [2:0] diff;
    if (io.push_valid[1] && !io.push_valid[0]) begin
      n_bad++;
      $display("FAIL lane_order: push_valid=%b", io.push_valid);
    end
    if (!rst) begin
      diff = dut.wp_q - dut.rp_q;
      chk("inv_count_le_depth", 64'(count <= CW'(DEPTH)), 64'd1);
      if (count == CW'(DEPTH))
        chk("inv_full_ptr_eq", 64'(diff), 64'd0);
      else
        chk("inv_count_ptr", 64'(count), 64'(diff));
      if (!flush && io.pop_valid && io.pop_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_unexpected: got %0h expected none",
                   io.pop_data);
        end else begin
          chk("pop_data", io.pop_data, sb.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; checks status against the bench occupancy model.
  task automatic cyc(input logic [1:0] pv, input logic [DW-1:0] d0,
                     input logic [DW-1:0] d1, input logic pr,
                     input logic fl, output int acc);
    logic [1:0] er;
    int np;
    io.push_valid = pv;
    io.push_data  = {d1, d0};
    io.pop_ready  = pr;
    flush         = fl;
    @(negedge clk);
    er[0] = !fl && (DEPTH - mcnt >= 1);
    er[1] = !fl && (DEPTH - mcnt >= 2);
    chk("push_ready", 64'(io.push_ready), 64'(er));
    chk("count", 64'(count), 64'(mcnt));
    chk("empty", 64'(empty), 64'(mcnt == 0));
    chk("full", 64'(full), 64'(mcnt == DEPTH));
    chk("pop_valid", 64'(io.pop_valid), 64'(mcnt != 0));
    acc = 0;
    if (pv[0] && er[0]) begin sb.push_back(d0); acc++; end
    if (pv[1] && er[1]) begin sb.push_back(d1); acc++; end
    np = (mcnt != 0 && pr && !fl) ? 1 : 0;
    if (fl) begin
      mcnt = 0;
      sb.delete();
    end else begin
      mcnt = mcnt + acc - np;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic pr);
    int a;
    cyc(2'b00, '0, '0, pr, 1'b0, a);
  endtask

  task automatic drain();
    int g = 0;
    while (mcnt > 0 && g < 40) begin
      idle(1'b1);
      g++;
    end
    chk("drain_done", 64'(mcnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a;
    int tot;
    int g;
    rst           = 1'b1;
    flush         = 1'b0;
    io.push_valid = '0;
    io.push_data  = '0;
    io.pop_ready  = 1'b0;
    @(negedge clk);
    chk("rst_pop_valid", 64'(io.pop_valid), 64'd0);
    chk("rst_pop_data", io.pop_data, 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_push_ready", 64'(io.push_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three single-lane pushes, head visible, then drain.
    cyc(2'b01, 64'hA, '0, 1'b0, 1'b0, a);
    cyc(2'b01, 64'hB, '0, 1'b0, 1'b0, a);
    cyc(2'b01, 64'hC, '0, 1'b0, 1'b0, a);
    io.push_valid = '0;
    io.pop_ready  = 1'b0;
    @(negedge clk);
    chk("abc_count", 64'(count), 64'd3);
    chk("abc_head", io.pop_data, 64'hA);
    @(posedge clk);
    #1;
    drain();

    // Dual pushes to full from an even start.
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, seq, seq + 1, 1'b0, 1'b0, a);
      seq += 64'(a);
    end
    idle(1'b0);
    chk("full_after4", 64'(full), 64'd1);
    drain();

    // Odd start: at count 7 only lane 0 is taken.
    cyc(2'b01, seq, '0, 1'b0, 1'b0, a);
    seq += 64'(a);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, seq, seq + 1, 1'b0, 1'b0, a);
      seq += 64'(a);
    end
    chk("lane0_only_at7", 64'(a), 64'd1);
    // Full with a pop: no pop-through, next cycle shows 7 / ready 01.
    cyc(2'b11, seq, seq + 1, 1'b1, 1'b0, a);
    chk("no_pop_through", 64'(a), 64'd0);
    idle(1'b0);
    chk("after_pop_count", 64'(count), 64'd7);
    drain();

    // Stream 40 entries with random pop_ready across pointer wrap.
    tot = 0;
    g   = 0;
    while (tot < 40 && g < 400) begin
      cyc(2'b11, seq, seq + 1, 1'($urandom_range(0, 1)), 1'b0, a);
      seq += 64'(a);
      tot += a;
      g++;
    end
    chk("stream_accepted", 64'(tot), 64'd40);
    drain();

    // Flush at count 5 with push and pop offered.
    cyc(2'b11, seq, seq + 1, 1'b0, 1'b0, a);
    seq += 64'(a);
    cyc(2'b11, seq, seq + 1, 1'b0, 1'b0, a);
    seq += 64'(a);
    cyc(2'b01, seq, '0, 1'b0, 1'b0, a);
    seq += 64'(a);
    cyc(2'b11, seq, seq + 1, 1'b1, 1'b1, a);
    chk("flush_no_push", 64'(a), 64'd0);
    idle(1'b0);

    // Asynchronous reset mid-stream at count 6.
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, seq, seq + 1, 1'b0, 1'b0, a);
      seq += 64'(a);
    end
    io.push_valid = 2'b11;
    io.pop_ready  = 1'b1;
    #2;
    chk("pre_arst_count", 64'(count), 64'd6);
    rst = 1'b1;
    #1;
    chk("arst_pop_valid", 64'(io.pop_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_push_ready", 64'(io.push_ready), 64'd0);
    mcnt = 0;
    sb.delete();
    io.push_valid = '0;
    io.pop_ready  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(io.push_ready), 64'd3);
    @(posedge clk);
    #1;
    cyc(2'b11, seq, seq + 1, 1'b0, 1'b0, a);
    seq += 64'(a);
    drain();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
